// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  fault;
    } fetch_entry_t;

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// Small synchronous FIFO with a fall-through head, a synchronous clear
// and an occupancy count; used for both the tag and instruction queues.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_reg] <= push_data;
    end

    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues PCs to instruction memory, pairs in-order responses
// with their PCs and queues them for decode. Optional FETCH_MISALIGN_CHECK_EN.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = FETCH_XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    localparam int CW = count_width(DEPTH);

    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic [CW-1:0] inst_count, tag_count;
    logic          credit, misaligned, fence_ok, fetch_ok;
    logic          phantom_head, phantom_done, resp_live;
    logic          tag_pop, tag_empty, tag_full;
    logic          inst_push, inst_pop, inst_empty, inst_full;
    logic [XLEN:0] tag_head;
    fetch_entry_t  inst_push_data, inst_head;

    assign credit = ({1'b0, inst_count} + {1'b0, outstanding_reg}) < (CW+1)'(DEPTH);

    // Tag entries carry {pc, fault}; a fault entry never visits memory.
    assign phantom_head = !tag_empty && tag_head[0];

`ifdef FETCH_MISALIGN_CHECK_EN
    // A phantom may only enter an empty tag queue and blocks real requests
    // until it retires, so it can never sit in front of a live response.
    assign misaligned = (pc_in[1:0] != 2'b00);
    assign fence_ok   = misaligned ? tag_empty : !phantom_head;
`else
    assign misaligned = 1'b0;
    assign fence_ok   = 1'b1;
`endif

    assign fetch_ok  = reset_n && pc_valid && credit && !flush && fence_ok;
    assign imem_req  = fetch_ok && !misaligned;
    assign imem_addr = pc_in;
    assign pc_ready  = fetch_ok && (misaligned || imem_gnt);

    assign resp_live    = imem_rvalid && (drop_reg == '0) && !flush;
    assign phantom_done = phantom_head && !flush;
    assign tag_pop      = resp_live || phantom_done;
    assign inst_push    = tag_pop;
    assign inst_pop     = !inst_empty && inst_ready && !flush;

    always_comb begin
        inst_push_data       = '0;
        inst_push_data.pc    = tag_head[XLEN:1];
        inst_push_data.instr = phantom_head ? NOP_INSTR : imem_rdata;
        inst_push_data.fault = phantom_head;
    end

    sync_fifo #(.WIDTH(XLEN + 1), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (pc_ready),
        .push_data ({pc_in, misaligned}),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (inst_push),
        .push_data (inst_push_data),
        .pop       (inst_pop),
        .pop_data  (inst_head),
        .full      (inst_full),
        .empty     (inst_empty),
        .count     (inst_count)
    );

    // On flush every surviving real request becomes a response to discard;
    // the same-cycle response and any phantom are already accounted for.
    always_comb begin
        outstanding_next = outstanding_reg + CW'(pc_ready) - CW'(imem_rvalid) - CW'(phantom_done);
        drop_next        = drop_reg;
        if (flush) begin
            outstanding_next = outstanding_reg - CW'(imem_rvalid) - CW'(phantom_head);
            drop_next        = outstanding_next;
        end else if (imem_rvalid && (drop_reg != '0)) begin
            drop_next = drop_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    assign inst_valid = !inst_empty;
    assign inst_data  = inst_valid ? inst_head.instr : NOP_INSTR;
    assign inst_pc    = inst_valid ? inst_head.pc : '0;
    assign inst_fault = inst_valid && inst_head.fault;

    a_resp_has_tag: assert property (@(posedge clk) disable iff (!reset_n)
        (imem_rvalid && drop_reg == '0) |-> (!tag_empty && !phantom_head));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pc_ready && tag_full && !tag_pop));
    a_inst_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(inst_push && inst_full && !inst_pop));
    a_tags_within_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
        tag_count <= outstanding_reg);

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and stall-randomised bench for fetch_buffer with an in-order
// memory model and a PC scoreboard.
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [XLEN-1:0] pc_in;
    logic            pc_valid;
    logic            pc_ready;
    logic            flush;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_fault  (inst_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
        bit          live;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] exp_q[$];
    int          deliv_cyc[$];
    logic [31:0] last_pc = '0;

    int checks = 0, failures = 0, cyc = 0, n_deliv = 0, n_acc = 0;
    int gnt_pct = 100, rv_pct = 100, rdy_pct = 100, lat = 1;
    bit rand_lat = 0, chk_occ = 0, flush_now = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe 1ns later, then account
    // for the handshakes that the next rising edge will perform.
    task automatic step();
        bit          rv, mis;
        logic [31:0] e;
        int          live, occ;
        @(negedge clk);
        rv          = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rv_pct);
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        pc_valid    = (pc_q.size() != 0);
        pc_in       = pc_valid ? pc_q[0] : 32'h0;
        inst_ready  = ($urandom_range(99) < rdy_pct);
        flush       = flush_now;
        #1;
        if (inst_valid && inst_ready && !flush) begin
            if (exp_q.size() == 0) begin
                check_value("spurious_delivery", inst_pc, 32'hFFFF_FFFF);
            end else begin
                e   = exp_q.pop_front();
                mis = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                mis = (e[1:0] != 2'b00);
`endif
                check_value("inst_pc", inst_pc, e);
                check_value("inst_data", inst_data, mis ? NOP_INSTR : mem_word(e));
                check_value("inst_fault", 32'(inst_fault), 32'(mis));
                n_deliv++;
                last_pc = e;
                deliv_cyc.push_back(cyc);
            end
        end
        if (rv) void'(mem_q.pop_front());
        if (flush) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
        end
        if (imem_req && imem_gnt)
            mem_q.push_back('{due: cyc + (rand_lat ? int'($urandom_range(3, 1)) : lat),
                              addr: imem_addr, live: 1'b1});
        if (pc_ready) begin
            exp_q.push_back(pc_in);
            void'(pc_q.pop_front());
            n_acc++;
        end
        if (chk_occ) begin
            live = 0;
            foreach (mem_q[i]) if (mem_q[i].live) live++;
            occ = mem_q.size() + exp_q.size() - live;
            check_value("occupancy_le_depth", 32'(occ <= DEPTH), 32'd1);
        end
        cyc++;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((pc_q.size() + mem_q.size() + exp_q.size()) != 0 && n < max_cyc) begin
            step();
            n++;
        end
        check_value("drain_pending", 32'(pc_q.size() + mem_q.size() + exp_q.size()), 32'd0);
        repeat (2) step();
    endtask

    initial begin
        int start, d0, a0;

        reset_n     = 1'b0;
        pc_valid    = 1'b1;
        pc_in       = 32'h40;
        flush       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_imem_req", 32'(imem_req), 32'd0);
        check_value("rst_pc_ready", 32'(pc_ready), 32'd0);
        check_value("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_value("rst_inst_data", inst_data, 32'h0000_0013);
        check_value("rst_inst_pc", inst_pc, 32'h0);
        check_value("rst_inst_fault", 32'(inst_fault), 32'd0);
        pc_valid = 1'b0;
        reset_n  = 1'b1;

        // Back-to-back fetch with single-cycle memory.
        pc_q = '{32'h0, 32'h4, 32'h8};
        deliv_cyc.delete();
        start = cyc;
        drain(50);
        check_value("b2b_first_cycle", 32'(deliv_cyc[0] - start), 32'd2);
        check_value("b2b_second_cycle", 32'(deliv_cyc[1] - start), 32'd3);
        check_value("b2b_third_cycle", 32'(deliv_cyc[2] - start), 32'd4);

        // Credit exhaustion with decode stalled.
        for (int i = 0; i < 10; i++) pc_q.push_back(32'h200 + 32'(4 * i));
        rdy_pct = 0;
        a0 = n_acc;
        repeat (6) step();
        check_value("full_accepts", 32'(n_acc - a0), 32'd4);
        check_value("full_imem_req", 32'(imem_req), 32'd0);
        check_value("full_pc_ready", 32'(pc_ready), 32'd0);
        rdy_pct = 100;
        step();
        rdy_pct = 0;
        step();
        check_value("credit_back_req", 32'(imem_req), 32'd1);
        rdy_pct = 100;
        drain(100);

        // Flush with two requests in flight on 3-cycle memory.
        lat  = 3;
        pc_q = '{32'h300, 32'h304};
        step();
        step();
        pc_q.push_back(32'h380);
        flush_now = 1'b1;
        step();
        check_value("flush_no_req", 32'(imem_req), 32'd0);
        check_value("flush_no_ready", 32'(pc_ready), 32'd0);
        flush_now = 1'b0;
        d0 = n_deliv;
        drain(50);
        check_value("flush_deliv_count", 32'(n_deliv - d0), 32'd1);
        check_value("flush_post_pc", last_pc, 32'h380);

        // Flush coinciding with a response and a decode handshake.
        lat  = 2;
        pc_q = '{32'h400, 32'h404, 32'h408};
        repeat (3) step();
        pc_q.push_back(32'h480);
        flush_now = 1'b1;
        step();
        check_value("coflush_head_valid", 32'(inst_valid), 32'd1);
        check_value("coflush_no_ready", 32'(pc_ready), 32'd0);
        flush_now = 1'b0;
        d0 = n_deliv;
        step();
        check_value("coflush_empty_after", 32'(inst_valid), 32'd0);
        check_value("coflush_new_accept", 32'(pc_ready), 32'd1);
        drain(50);
        check_value("coflush_deliv_count", 32'(n_deliv - d0), 32'd1);
        check_value("coflush_post_pc", last_pc, 32'h480);

`ifdef FETCH_MISALIGN_CHECK_EN
        lat  = 1;
        pc_q = '{32'h6};
        step();
        check_value("mis_no_req", 32'(imem_req), 32'd0);
        check_value("mis_ready", 32'(pc_ready), 32'd1);
        drain(20);
        check_value("mis_last_pc", last_pc, 32'h6);
`endif

        // Random grant/response/decode stalls over 1000 sequential PCs.
        rand_lat = 1;
        gnt_pct  = 70;
        rv_pct   = 70;
        rdy_pct  = 70;
        chk_occ  = 1;
        for (int i = 0; i < 1000; i++) pc_q.push_back(32'h1_0000 + 32'(4 * i));
        d0 = n_deliv;
        drain(20000);
        chk_occ = 0;
        check_value("random_deliv_count", 32'(n_deliv - d0), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
